// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing generator gated by PLL lock qualification.
//
// Waits for the PLL to report lock, requires LOCK_SETTLE+1 consecutive
// locked samples, then scans an H_TOTAL x V_TOTAL raster.
//
// Ports
//   clock_in    in   pixel clock (only clock)
//   reset_n     in   synchronous active-low reset
//   locked      in   PLL lock indicator
//   hsync       out  horizontal sync, active-low
//   vsync       out  vertical sync, active-low
//   de          out  display enable (visible pixel)
//   x, y        out  visible column/row, 0 outside active video
//   frame_start out  one-cycle pulse at position (0,0)
//   running     out  high while scanning
module vga_sync_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int LOCK_SETTLE = 16
) (
    input  logic       clock_in,
    input  logic       reset_n,
    input  logic       locked,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_start,
    output logic       running
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int SW      = (LOCK_SETTLE < 1) ? 1 : $clog2(LOCK_SETTLE + 1);

    // 11-bit constants so a 1024 total (counter max 1023) still compares cleanly
    localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_ACT   = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [SW-1:0] SETTLE_MAX = SW'(LOCK_SETTLE);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
        $error("vga_sync_gen: H_TOTAL and V_TOTAL must be <= 1024");
    end

    typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [9:0]    h_q, h_d, v_q, v_d;
    logic          hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
    logic [9:0]    x_q, x_d, y_q, y_d;
    logic          frame_start_q, frame_start_d, running_q, running_d;
    logic [10:0]   hx, vx;
    logic          act;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        h_d      = h_q;
        v_d      = v_q;
        case (state_q)
            WAIT_LOCK: begin
                settle_d = '0;
                h_d      = '0;
                v_d      = '0;
                if (locked) begin
                    state_d  = SETTLE;
                    settle_d = SW'(1);
                end
            end
            SETTLE: begin
                if (!locked) begin
                    state_d  = WAIT_LOCK;
                    settle_d = '0;
                end else if (settle_q >= SETTLE_MAX) begin
                    // this sample is the LOCK_SETTLE+1-th in a row
                    state_d  = RUN;
                    settle_d = '0;
                    h_d      = '0;
                    v_d      = '0;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            RUN: begin
                if (!locked) begin
                    state_d = WAIT_LOCK;
                    h_d     = '0;
                    v_d     = '0;
                end else if ({1'b0, h_q} == H_LAST) begin
                    h_d = '0;
                    v_d = ({1'b0, v_q} == V_LAST) ? 10'd0 : v_q + 10'd1;
                end else begin
                    h_d = h_q + 10'd1;
                end
            end
            default: begin
                state_d  = WAIT_LOCK;
                settle_d = '0;
                h_d      = '0;
                v_d      = '0;
            end
        endcase

        // Outputs decode the *next* position so the registered outputs line
        // up with the position counters without an extra cycle of latency.
        act           = (state_d == RUN);
        hx            = {1'b0, h_d};
        vx            = {1'b0, v_d};
        hsync_d       = !(act && hx >= HS_BEG && hx < HS_END);
        vsync_d       = !(act && vx >= VS_BEG && vx < VS_END);
        de_d          = act && hx < H_ACT && vx < V_ACT;
        x_d           = de_d ? h_d : 10'd0;
        y_d           = de_d ? v_d : 10'd0;
        frame_start_d = act && h_d == 10'd0 && v_d == 10'd0;
        running_d     = act;
    end

    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            state_q       <= WAIT_LOCK;
            settle_q      <= '0;
            h_q           <= '0;
            v_q           <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            frame_start_q <= 1'b0;
            running_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            settle_q      <= settle_d;
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_start_q <= frame_start_d;
            running_q     <= running_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign frame_start = frame_start_q;
    assign running     = running_q;

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL expose parameters (name, default, meaning): H_ACTIVE 640 visible pixels/line; H_FP 16 front porch; H_SYNC 96 hsync width; H_BP 48 back porch; V_ACTIVE 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33; LOCK_SETTLE 16 consecutive locked cycles before output starts.
REQ-002 SHALL have port clock_in, input, 1 bit: 25 MHz pixel clock from the PLL clock_out; the only clock.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL have port locked, input, 1 bit: PLL lock indicator, sampled on clock_in.
REQ-005 SHALL have port hsync, output, 1 bit: horizontal sync, active-low.
REQ-006 SHALL have port vsync, output, 1 bit: vertical sync, active-low.
REQ-007 SHALL have port de, output, 1 bit: display enable, high during visible pixels.
REQ-008 SHALL have port x, output, 10 bits: visible column, 0 outside active video.
REQ-009 SHALL have port y, output, 10 bits: visible row, 0 outside active video.
REQ-010 SHALL have port frame_start, output, 1 bit: one-cycle pulse at position (0,0).
REQ-011 SHALL have port running, output, 1 bit: high while in RUN.

Function
REQ-012 SHALL derive H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800) and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525); both SHALL be at most 1024.
REQ-013 SHALL implement states WAIT_LOCK, SETTLE and RUN.
REQ-014 WAIT_LOCK: settle counter and position held at 0; on an edge sampling locked=1, next state is SETTLE with settle count 1.
REQ-015 SETTLE: each edge sampling locked=1 increments the settle count; an edge sampling locked=0 returns the FSM to WAIT_LOCK with count 0.
REQ-016 SETTLE -> RUN SHALL occur on the edge where the LOCK_SETTLE+1-th consecutive locked=1 sample is taken, i.e. 16 edges after entering SETTLE at default.
REQ-017 In RUN, position (h,v) SHALL be (0,0) in the first RUN cycle; h increments every cycle and wraps H_TOTAL-1 -> 0; v increments when h wraps and wraps V_TOTAL-1 -> 0.
REQ-018 Any edge in RUN sampling locked=0 SHALL move the FSM to WAIT_LOCK; outputs go idle in that same cycle.
REQ-019 Outputs SHALL be registered and reflect the current position with zero added latency: in the cycle where position is (h,v), outputs SHALL be:
- hsync = 0 iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751)
- vsync = 0 iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (490..491)
- de = 1 iff h < H_ACTIVE and v < V_ACTIVE
- x = h and y = v when de=1, else 0
- frame_start = 1 iff h=0 and v=0
REQ-020 Idle outputs (WAIT_LOCK, SETTLE): hsync=1, vsync=1, de=0, x=0, y=0, frame_start=0, running=0.
REQ-021 hsync SHALL keep toggling during vertical blanking; vsync transitions SHALL coincide with h=0.

Reset
REQ-022 reset_n=0 sampled on an edge SHALL force WAIT_LOCK, counters 0 and idle outputs after that edge, regardless of locked or the current state.
REQ-023 Reset SHALL take precedence over all FSM transitions; after reset_n returns high, the lock qualification restarts from a count of 0.

Verification
REQ-024 Reset then lock: reset_n low 3 cycles with locked=1, then release -> outputs idle; running=1 and frame_start=1 exactly 16 edges after entering SETTLE; x=0, y=0, de=1 in that cycle.
REQ-025 Line timing in RUN -> hsync period 800 cycles, low for 96 cycles starting 656 cycles after de rises; de high 640 cycles per visible line; x runs 0..639.
REQ-026 Frame timing -> vsync low for 1600 cycles starting at line 490; frame_start period 420000 cycles; last visible pixel is x=639, y=479, and de=0 on the next cycle.
REQ-027 Lock glitch in SETTLE: locked high 10 cycles, low 1 cycle, then high -> running stays 0 until 16 edges after re-entering SETTLE.
REQ-028 Lock loss in RUN at h=300, v=100 -> all outputs idle in that same cycle; after re-lock and settle, restart at (0,0) with frame_start=1.
REQ-029 Reset mid-frame at h=700, v=491 (hsync=0, vsync=0) -> both outputs high after the reset edge; no runt pulse.
